// File: rtl/seg_digit_edit.sv
// Four-digit BCD editor with a multiplexed common-anode 7-segment driver.
// k0 bumps the selected digit (mod 10, no carry); k1 moves the selection.
module seg_digit_edit #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        k0,
  input  logic        k1,
  output logic [15:0] digits,
  output logic [1:0]  sel,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam logic [19:0] CNT_MAX = 20'(SCAN_DIV - 1);

  logic [19:0] scan_cnt;
  logic [1:0]  scan_idx;
  logic [3:0]  cur_digit;
  logic [3:0]  edit_digit;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_digit  = digits[{scan_idx, 2'b00} +: 4];
    edit_digit = digits[{sel, 2'b00} +: 4];
  end

  // Increment uses the pre-update sel, so k0+k1 together edit the old digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= 16'h0000;
      sel    <= 2'd0;
    end else begin
      if (k0) begin
        digits[{sel, 2'b00} +: 4] <= (edit_digit >= 4'd9) ? 4'd0 : edit_digit + 4'd1;
      end
      if (k1) begin
        sel <= sel + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= 20'd0;
      scan_idx <= 2'd0;
    end else if (scan_cnt >= CNT_MAX) begin
      scan_cnt <= 20'd0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 20'd1;
    end
  end

  // Decimal point lights on the digit currently under edit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b0001 << scan_idx);
      seg <= {(scan_idx != sel), decode(cur_digit)};
    end
  end

endmodule

// File: tb/tb_seg_digit_edit.sv
// Bench for seg_digit_edit: directed edit/scan/reset steps plus random key
// traffic, checked against a digit-array and cycle-count reference model.
module tb_seg_digit_edit;

  localparam int SD = 4;

  logic        clk;
  logic        rst_n;
  logic        k0;
  logic        k1;
  logic [15:0] digits;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [7:0]  seg;

  int total;
  int bad;

  // Reference model: decimal digits, selected index, edges since reset.
  int md [4];
  int msel;
  int p;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_digit_edit #(.SCAN_DIV(SD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .k0     (k0),
    .k1     (k1),
    .digits (digits),
    .sel    (sel),
    .an     (an),
    .seg    (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_digits();
    return 16'(md[3] * 4096 + md[2] * 256 + md[1] * 16 + md[0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) md[i] = 0;
    msel = 0;
    p    = 0;
  endtask

  // Reset with keys optionally held, checked before any clock edge arrives.
  task automatic do_reset(input logic hold_keys);
    k0    = hold_keys;
    k1    = hold_keys;
    rst_n = 1'b0;
    #2;
    chk("rst_an",     {12'd0, an},  16'h000F);
    chk("rst_seg",    {8'd0, seg},  16'h00FF);
    chk("rst_digits", digits,       16'h0000);
    chk("rst_sel",    {14'd0, sel}, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_hold_digits", digits,       16'h0000);
    chk("rst_hold_sel",    {14'd0, sel}, 16'h0000);
    chk("rst_hold_an",     {12'd0, an},  16'h000F);
    rst_n = 1'b1;
    k0    = 1'b0;
    k1    = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic a, input logic b);
    int         idx;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    logic [7:0] code;
    idx   = (p / SD) % 4;
    an_e  = ~(4'b0001 << idx);
    code  = seg_tab[md[idx]];
    seg_e = {(idx == msel) ? 1'b0 : 1'b1, code[6:0]};
    k0 = a;
    k1 = b;
    @(posedge clk);
    #1;
    k0 = 1'b0;
    k1 = 1'b0;
    if (a) md[msel] = (md[msel] + 1) % 10;
    if (b) msel = (msel + 1) % 4;
    p++;
    chk("digits", digits,       model_digits());
    chk("sel",    {14'd0, sel}, 16'(msel));
    chk("an",     {12'd0, an},  {12'd0, an_e});
    chk("seg",    {8'd0, seg},  {8'd0, seg_e});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k0    = 1'b0;
    k1    = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    do_reset(1'b0);

    // First edge after release: digit 0 showing "0" with dp lit.
    step(1'b0, 1'b0);
    chk("first_an",  {12'd0, an}, 16'h000E);
    chk("first_seg", {8'd0, seg}, 16'h0040);

    // Ten increments on digit 0: 1..9 then back to 0, no carry.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    chk("wrap_digits", digits, 16'h0000);

    // Four selects walk 1,2,3,0 without touching digits.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("selwrap_sel",    {14'd0, sel}, 16'h0000);
    chk("selwrap_digits", digits,       16'h0000);

    // k1, 3x k0, k1, k0.
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("seq_digits", digits,       16'h0130);
    chk("seq_sel",    {14'd0, sel}, 16'h0002);

    // Digit 3 to 9, then simultaneous k0+k1 at sel=3.
    step(1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
    chk("pre_both_digits", digits, 16'h9130);
    step(1'b1, 1'b1);
    chk("both_digits", digits,       16'h0130);
    chk("both_sel",    {14'd0, sel}, 16'h0000);

    // Scan pattern with 1234, sel=0, from a fresh reset.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    chk("scan_digits", digits, 16'h1234);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);

    // Random key traffic, including multi-cycle held pulses.
    for (int i = 0; i < 150; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mid-scan reset with keys held: everything clears at once.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    do_reset(1'b1);
    step(1'b0, 1'b0);
    chk("post_an",  {12'd0, an}, 16'h000E);
    chk("post_seg", {8'd0, seg}, 16'h0040);
    for (int i = 0; i < 30; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
